radix2_stage_ctrl: RTL
======================

# radix2_stage_ctrl

Sequencer for the in-place, memory-based radix-2 DIT FFT built around the single `RADIX2` butterfly. After `start`, it walks all log2(N) stages and N/2 butterflies per stage. Each cycle it issues one operand-pair read address plus a twiddle ROM address. It then produces the butterfly enable, `en_modify`, and the delayed write-back addresses, and drains the pipeline between stages so no read overtakes a pending write.

## Interface
- `LOG2N`, 4, log2 of FFT length; N = 2^LOG2N (4..12).
- `RD_LAT`, 1, read latency in cycles of both the data RAM and the twiddle ROM (1..3).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a transform; sampled only in IDLE.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when the last write-back has completed.
- `stage`  out  ceil(log2(LOG2N))  current stage index s, on the read side.
- `rd_en`  out  1  read issue strobe.
- `rd_addr1`, `rd_addr2`  out  LOG2N each  operand addresses.
- `tw_addr`  out  LOG2N-1  twiddle ROM index.
- `bf_en`  out  1  to `RADIX2.en`; operands are valid at the butterfly.
- `en_modify`  out  1  to `RADIX2.en_modify`; qualifies the final stage.
- `wr_en`  out  1  write-back strobe.
- `wr_addr1`, `wr_addr2`  out  LOG2N each  write-back addresses.

## Operation
- The data RAM is loaded in bit-reversed order by the loader before `start`. The output is in natural order.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: `start`=1 moves to RUN with s=0 and b=0.
  - RUN: one butterfly b is issued per cycle. After b = N/2-1, go to DRAIN.
  - DRAIN: counts RD_LAT+1 cycles. If s < LOG2N-1, then s++, b=0, and go to RUN. Otherwise go to DONE.
  - DONE: one cycle with `done`=1, then IDLE.
- Address generation for stage s and butterfly b, with span = 2^s:
  - pos = b & (span-1)
  - grp = b >> s
  - `rd_addr1` = (grp << (s+1)) | pos
  - `rd_addr2` = `rd_addr1` + span
  - `tw_addr` = pos << (LOG2N-1-s)
  - All arithmetic is unsigned and truncated to the port widths; none can overflow.
- `rd_en`=1 exactly in RUN cycles.
- A valid/address/flag shift pipeline carries each issue forward:
  - `bf_en` and `en_modify` are the issue's `rd_en` and (s == LOG2N-1) delayed RD_LAT cycles. `en_modify` is forced 0 whenever `bf_en`=0.
  - `wr_en`, `wr_addr1` and `wr_addr2` are `rd_en`, `rd_addr1` and `rd_addr2` delayed RD_LAT+1 cycles. The butterfly result is registered by the datapath one cycle after `bf_en`.
- `start` while busy or in DONE is ignored; there is no queueing.
- Address outputs hold their last value when their strobe is low. Consumers must qualify them with `rd_en` or `wr_en`.

## Timing
- Reset values: `busy`=`done`=`rd_en`=`bf_en`=`en_modify`=`wr_en`=0; `stage`, all address and `tw_addr` outputs = 0; FSM = IDLE; pipeline valids cleared.
- If `start` is sampled at edge k, the first `rd_en` occurs in cycle k+1 and `busy` rises in cycle k+1.
- Each stage lasts N/2 RUN cycles plus RD_LAT+1 DRAIN cycles.
- The last write of stage s occurs exactly in the final DRAIN cycle of that stage. The first read of stage s+1 follows it in the next cycle, so there is no read-before-write hazard.
- `done` is high in cycle k+1+LOG2N·(N/2+RD_LAT+1). `busy` is low in that cycle.
- Example: LOG2N=4, RD_LAT=1 gives `done` at k+41.
- A `rst` mid-transform takes effect at the next edge: FSM goes to IDLE, all strobes are 0 from the following cycle, in-flight pipeline entries are discarded with no trailing `wr_en`, and `done` is not pulsed.
- `rst` and `start` high together: reset wins.

## Test plan
- Reset, then `start` pulse (LOG2N=4, RD_LAT=1): stage 0 issues pairs (0,1),(2,3)…(14,15) with `tw_addr`=0. Stage 1 issues (0,2),(1,3),(4,6),(5,7)… with `tw_addr` 0,4,0,4…
- Same run, stage 3: pairs (b, b+8) for b=0..7 with `tw_addr`=b, and `en_modify`=1 on all 8 `bf_en` cycles only. `done` is at k+41 and `busy` totals 40 cycles.
- Pipeline alignment: every `bf_en` occurs exactly 1 cycle after its `rd_en`, and every `wr_en` exactly 2 cycles after it with matching addresses. 16×4 writes cover each address exactly twice per stage pair, and the last write precedes the next stage's first read.
- RD_LAT=3: DRAIN is 4 cycles per stage. `done` is at k+1+4·(8+4)=k+49. The `wr_en` lag is 4 cycles.
- `rst` asserted during stage 2 RUN: from the cycle after, `wr_en`=`bf_en`=`busy`=0 and there is no `done`. A new `start` gives a full correct transform from stage 0.
- `start` held high throughout: exactly one transform per IDLE visit, starts back-to-back 1 cycle after `done`, and no `start` is accepted during RUN, DRAIN or DONE.

Source files
------------

// File: rtl/radix2_stage_ctrl_if.sv
// Control bundle between the radix-2 stage sequencer and the RAM/ROM/butterfly datapath.
// The sequencer drives everything except start.
interface radix2_stage_ctrl_if #(
  parameter int LOG2N = 4
) ();
  localparam int SW = $clog2(LOG2N);

  logic             start;
  logic             busy;
  logic             done;
  logic [SW-1:0]    stage;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr1;
  logic [LOG2N-1:0] rd_addr2;
  logic [LOG2N-2:0] tw_addr;
  logic             bf_en;
  logic             en_modify;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr1;
  logic [LOG2N-1:0] wr_addr2;

  modport master (
    input  start,
    output busy, done, stage, rd_en, rd_addr1, rd_addr2, tw_addr,
           bf_en, en_modify, wr_en, wr_addr1, wr_addr2
  );

  modport slave (
    output start,
    input  busy, done, stage, rd_en, rd_addr1, rd_addr2, tw_addr,
           bf_en, en_modify, wr_en, wr_addr1, wr_addr2
  );
endinterface

// File: rtl/radix2_stage_ctrl.sv
// In-place radix-2 DIT FFT sequencer: walks LOG2N stages of N/2 butterflies, issues
// read/twiddle addresses, and delays them to the butterfly enable and write-back ports.
module radix2_stage_ctrl #(
  parameter int LOG2N  = 4,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  radix2_stage_ctrl_if.master bus
);
  localparam int SW = $clog2(LOG2N);
  localparam int AW = LOG2N;
  localparam int BW = LOG2N - 1;
  localparam int N  = 1 << LOG2N;

  localparam logic [BW-1:0] B_LAST = BW'(N / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [1:0]    D_LAST = 2'(RD_LAT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [BW-1:0] tw;
  } issue_t;

  // Operand pair and twiddle index for butterfly bi of stage st (span = 2^st).
  function automatic issue_t issue_of(input logic [SW-1:0] st, input logic [BW-1:0] bi);
    logic [AW-1:0] span;
    logic [AW-1:0] pos;
    logic [AW-1:0] grp;
    issue_t        r;
    span = AW'(1) << st;
    pos  = AW'(bi) & (span - AW'(1));
    grp  = AW'(bi) >> st;
    r.a1 = (grp << (int'(st) + 1)) | pos;
    r.a2 = r.a1 + span;
    r.tw = BW'(pos << (LOG2N - 1 - int'(st)));
    return r;
  endfunction

  state_t        state;
  logic [SW-1:0] s;
  logic [BW-1:0] b;
  logic [1:0]    dcnt;
  logic          busy_q;
  logic          done_q;
  logic          rd_en_q;
  issue_t        iss_q;

  logic [RD_LAT:0]   vld_pipe;
  logic [RD_LAT-1:0] mod_pipe;
  logic [AW-1:0]     a1_pipe [RD_LAT+1];
  logic [AW-1:0]     a2_pipe [RD_LAT+1];

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s       <= '0;
      b       <= '0;
      dcnt    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      iss_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= RUN;
            s       <= '0;
            b       <= '0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            iss_q   <= issue_of('0, '0);
          end
        end
        RUN: begin
          if (b == B_LAST) begin
            state   <= DRAIN;
            dcnt    <= '0;
            rd_en_q <= 1'b0;
          end else begin
            b     <= b + BW'(1);
            iss_q <= issue_of(s, b + BW'(1));
          end
        end
        DRAIN: begin
          // Hold off the next stage until the last write of this one has landed.
          if (dcnt != D_LAST) begin
            dcnt <= dcnt + 2'd1;
          end else if (s != S_LAST) begin
            state   <= RUN;
            s       <= s + SW'(1);
            b       <= '0;
            rd_en_q <= 1'b1;
            iss_q   <= issue_of(s + SW'(1), '0);
          end else begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Valid bits shift every cycle; address slots only advance with a valid entry,
  // so write-back addresses hold their last value while wr_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      mod_pipe <= '0;
      // NOTE: the address slots are a handful of flops, not RAM, so clearing them is
      // cheap and gives the required zero write-back addresses out of reset.
      for (int i = 0; i <= RD_LAT; i++) begin
        a1_pipe[i] <= '0;
        a2_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_en_q;
      mod_pipe[0] <= rd_en_q && (s == S_LAST);
      for (int i = 1; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      for (int i = 1; i < RD_LAT; i++)  mod_pipe[i] <= mod_pipe[i-1];
      if (rd_en_q) begin
        a1_pipe[0] <= iss_q.a1;
        a2_pipe[0] <= iss_q.a2;
      end
      for (int i = 1; i <= RD_LAT; i++) begin
        if (vld_pipe[i-1]) begin
          a1_pipe[i] <= a1_pipe[i-1];
          a2_pipe[i] <= a2_pipe[i-1];
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = s;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr1  = iss_q.a1;
  assign bus.rd_addr2  = iss_q.a2;
  assign bus.tw_addr   = iss_q.tw;
  assign bus.bf_en     = vld_pipe[RD_LAT-1];
  assign bus.en_modify = mod_pipe[RD_LAT-1];
  assign bus.wr_en     = vld_pipe[RD_LAT];
  assign bus.wr_addr1  = a1_pipe[RD_LAT];
  assign bus.wr_addr2  = a2_pipe[RD_LAT];
endmodule
